mem_ctrl: RTL and testbench

Parametrised data/instruction memory for the RV32C core. It replaces the single-cycle combinational data path with a request/done handshake. Accesses of 1, 2 or 4 bytes that stay inside one 32-bit word complete in one beat. Misaligned accesses that cross a word boundary are split into two sequential beats, so the storage needs only one write port. The instruction fetch port stays combinational.

---
 rtl/mem_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: word-organised memory with a combinational fetch port and a request/done data port.
// Data accesses that cross a word take two beats; define MEM_CTRL_RANGE_CHECK_EN to reject out-of-range addresses.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | ready to accept a request
//   SECOND | second beat of a word-crossing access pending
module mem_ctrl #(
    parameter int DEPTH = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iaddr,
    output logic [15:0] iread,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [2:0]  dsize,
    input  logic        dread_se,
    output logic        d_busy,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err
);
    localparam int IDX_BITS = $clog2(DEPTH);

    typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

    logic [31:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic                done_q, done_d, err_q, err_d;
    logic [31:0]         rdata_q, rdata_d, hold_q, hold_d, wdata2_q, wdata2_d;
    logic [IDX_BITS-1:0] idx2_q, idx2_d;
    logic [1:0]          off_q, off_d;
    logic [3:0]          be2_q, be2_d;
    logic [2:0]          size_q, size_d;
    logic                we_q, we_d, se_q, se_d;

    logic [IDX_BITS-1:0] idx1, rd_idx;
    logic [1:0]          off;
    logic [3:0]          mask;
    logic [7:0]          be_full;
    logic [63:0]         wfull;
    logic                legal, split, reject;
    logic [31:0]         rd_word, beat2_raw, iword;
    logic                mem_we;
    logic [3:0]          mem_be;
    logic [31:0]         mem_wdata;
    logic                unused_addr;

    function automatic logic [31:0] fmt(input logic [31:0] raw, input logic [2:0] sz, input logic se);
        case (sz)
            3'b001:  fmt = {{24{se & raw[7]}}, raw[7:0]};
            3'b010:  fmt = {{16{se & raw[15]}}, raw[15:0]};
            default: fmt = raw;
        endcase
    endfunction

    assign off     = daddr[1:0];
    assign idx1    = daddr[IDX_BITS+1:2];
    assign legal   = (dsize == 3'b001) || (dsize == 3'b010) || (dsize == 3'b100);
    assign mask    = dsize[0] ? 4'b0001 : (dsize[1] ? 4'b0011 : 4'b1111);
    // Lanes 7:4 of the shifted enable/data belong to the following word.
    assign be_full = {4'b0000, mask} << off;
    assign wfull   = {32'h0, dwdata} << {off, 3'b000};
    assign split   = legal && (be_full[7:4] != 4'b0000);

`ifdef MEM_CTRL_RANGE_CHECK_EN
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;
    logic [2:0]  nbytes;
    logic [32:0] last_byte;
    assign nbytes    = dsize[0] ? 3'd1 : (dsize[1] ? 3'd2 : 3'd4);
    assign last_byte = {1'b0, daddr} + {30'h0, nbytes} - 33'd1;
    assign reject    = ~legal | (last_byte >= LIMIT);
`else
    assign reject = ~legal;
`endif

    assign rd_idx    = (state_q == SECOND) ? idx2_q : idx1;
    assign rd_word   = mem[rd_idx];
    assign beat2_raw = hold_q | (rd_word << (6'd32 - {1'b0, off_q, 3'b000}));

    assign iword = mem[iaddr[IDX_BITS+1:2]];
    assign iread = iaddr[1] ? iword[31:16] : iword[15:0];

    assign unused_addr = ^{iaddr[31:IDX_BITS+2], iaddr[0], daddr[31:IDX_BITS+2]};

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        hold_d    = hold_q;
        wdata2_d  = wdata2_q;
        idx2_d    = idx2_q;
        off_d     = off_q;
        be2_d     = be2_q;
        size_d    = size_q;
        we_d      = we_q;
        se_d      = se_q;
        mem_we    = 1'b0;
        mem_be    = be_full[3:0];
        mem_wdata = wfull[31:0];
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    if (reject) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        mem_we = d_we;
                        if (split) begin
                            state_d  = SECOND;
                            hold_d   = rd_word >> {off, 3'b000};
                            wdata2_d = wfull[63:32];
                            idx2_d   = idx1 + IDX_BITS'(1);
                            off_d    = off;
                            be2_d    = be_full[7:4];
                            size_d   = dsize;
                            we_d     = d_we;
                            se_d     = dread_se;
                        end else begin
                            done_d = 1'b1;
                            if (!d_we) rdata_d = fmt(rd_word >> {off, 3'b000}, dsize, dread_se);
                        end
                    end
                end
            end
            SECOND: begin
                state_d   = IDLE;
                done_d    = 1'b1;
                mem_we    = we_q;
                mem_be    = be2_q;
                mem_wdata = wdata2_q;
                if (!we_q) rdata_d = fmt(beat2_raw, size_q, se_q);
            end
        endcase
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int j = 0; j < 4; j++) begin
                if (mem_be[j]) mem[rd_idx][8*j +: 8] <= mem_wdata[8*j +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            hold_q   <= 32'h0;
            wdata2_q <= 32'h0;
            idx2_q   <= '0;
            off_q    <= 2'b00;
            be2_q    <= 4'h0;
            size_q   <= 3'b000;
            we_q     <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            hold_q   <= hold_d;
            wdata2_q <= wdata2_d;
            idx2_q   <= idx2_d;
            off_q    <= off_d;
            be2_q    <= be2_d;
            size_q   <= size_d;
            we_q     <= we_d;
            se_q     <= se_d;
        end
    end

    assign d_busy  = (state_q == SECOND);
    assign d_done  = done_q;
    assign d_err   = err_q;
    assign d_rdata = rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table of data accesses with a completion scoreboard,
// plus hand-written fetch and reset-during-second-beat sequences.
module tb_mem_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] iaddr;
    logic [15:0] iread;
    logic        d_req, d_we, dread_se;
    logic [31:0] daddr, dwdata;
    logic [2:0]  dsize;
    logic        d_busy, d_done, d_err;
    logic [31:0] d_rdata;

    mem_ctrl #(.DEPTH(512)) dut (
        .clock(clock), .reset(reset), .iaddr(iaddr), .iread(iread),
        .d_req(d_req), .d_we(d_we), .daddr(daddr), .dwdata(dwdata),
        .dsize(dsize), .dread_se(dread_se), .d_busy(d_busy), .d_done(d_done),
        .d_rdata(d_rdata), .d_err(d_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic        se;
        logic        chk;
        logic [31:0] rdata;
        logic        err;
        logic        split;
    } vec_t;

    typedef struct {
        int          cyc;
        int          id;
        logic        chk;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    localparam logic [2:0] B = 3'b001, H = 3'b010, W = 3'b100;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   next_id = 0;

    always @(posedge clock) cyc++;

    task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] size, input logic se, input logic chk,
                       input logic [31:0] rdata, input logic err, input logic split);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.se = se;
        v.chk = chk; v.rdata = rdata; v.err = err; v.split = split;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance with d_req still asserted.
    task automatic issue(input vec_t v);
        exp_t e;
        int   guard = 0;
        d_req = 1'b1; d_we = v.we; daddr = v.addr; dwdata = v.wdata;
        dsize = v.size; dread_se = v.se;
        while (d_busy && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 10) begin
            n_cmp++; n_fail++;
            $display("FAIL busy_timeout: d_busy still %b after %0d cycles, expected 0", d_busy, guard);
        end
        @(posedge clock);
        #1;
        e.cyc = cyc + (v.split ? 1 : 0);
        e.id = next_id; e.chk = v.chk; e.rdata = v.rdata; e.err = v.err;
        next_id++;
        sb.push_back(e);
        check($sformatf("busy_after_accept[%0d]", e.id), {31'h0, d_busy}, {31'h0, v.split});
        @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if (d_done !== 1'b1 || d_err !== e.err) begin
                    n_fail++;
                    $display("FAIL done_err[%0d]: got done=%b err=%b, expected done=1 err=%b",
                             e.id, d_done, d_err, e.err);
                end
                if (e.chk) begin
                    n_cmp++;
                    if (d_rdata !== e.rdata) begin
                        n_fail++;
                        $display("FAIL rdata[%0d]: got %h, expected %h", e.id, d_rdata, e.rdata);
                    end
                end
            end else if (d_done !== 1'b0 || d_err !== 1'b0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_done: got done=%b err=%b at cycle %0d, expected 0 0",
                         d_done, d_err, cyc);
            end
        end
    end

    task automatic drain();
        int g = 0;
        while (sb.size() > 0 && g < 20) begin
            @(negedge clock);
            g++;
        end
        if (sb.size() > 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: %0d completions outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [2:0] size, input logic se,
                      input logic [31:0] exp, input logic split);
        vec_t v;
        v.we = 1'b0; v.addr = addr; v.wdata = 32'h0; v.size = size; v.se = se;
        v.chk = 1'b1; v.rdata = exp; v.err = 1'b0; v.split = split;
        issue(v);
    endtask

    initial begin
        reset = 1'b1; d_req = 1'b0; d_we = 1'b0; daddr = 32'h0; dwdata = 32'h0;
        dsize = W; dread_se = 1'b0; iaddr = 32'h0;
        repeat (3) @(negedge clock);
        check("reset_busy",  {31'h0, d_busy}, 32'h0);
        check("reset_done",  {31'h0, d_done}, 32'h0);
        check("reset_err",   {31'h0, d_err},  32'h0);
        check("reset_rdata", d_rdata,         32'h0);
        reset = 1'b0;
        @(negedge clock);

        add(1, 32'h10, 32'hDEADBEEF, W, 0, 0, 32'h0, 0, 0);
        add(0, 32'h10, 32'h0,        W, 0, 1, 32'hDEADBEEF, 0, 0);
        add(1, 32'h20, 32'h0, W, 0, 0, 32'h0, 0, 0);
        add(1, 32'h24, 32'h0, W, 0, 0, 32'h0, 0, 0);
        add(1, 32'h28, 32'h0, W, 0, 0, 32'h0, 0, 0);
        add(1, 32'h23, 32'h11223344, W, 0, 0, 32'h0, 0, 1);
        add(0, 32'h20, 32'h0, W, 0, 1, 32'h44000000, 0, 0);
        add(0, 32'h24, 32'h0, W, 0, 1, 32'h00112233, 0, 0);
        add(0, 32'h23, 32'h0, W, 0, 1, 32'h11223344, 0, 1);
        add(1, 32'h27, 32'h00000080, B, 0, 0, 32'h0, 0, 0);
        add(1, 32'h28, 32'h000000F0, B, 0, 0, 32'h0, 0, 0);
        add(0, 32'h27, 32'h0, H, 1, 1, 32'hFFFFF080, 0, 1);
        add(0, 32'h27, 32'h0, H, 0, 1, 32'h0000F080, 0, 1);
        add(1, 32'h0, 32'hFFFFFFA1, B, 0, 0, 32'h0, 0, 0);
        add(1, 32'h1, 32'hFFFFFFB2, B, 0, 0, 32'h0, 0, 0);
        add(1, 32'h2, 32'hFFFFFFC3, B, 0, 0, 32'h0, 0, 0);
        add(1, 32'h3, 32'hFFFFFFD4, B, 0, 0, 32'h0, 0, 0);
        add(0, 32'h0, 32'h0, W, 0, 1, 32'hD4C3B2A1, 0, 0);
        add(0, 32'h3, 32'h0, B, 1, 1, 32'hFFFFFFD4, 0, 0);
        add(0, 32'h1, 32'h0, B, 0, 1, 32'h000000B2, 0, 0);
        add(0, 32'h2, 32'h0, H, 1, 1, 32'hFFFFD4C3, 0, 0);
        add(1, 32'h0, 32'h0, 3'b011, 0, 1, 32'h0, 1, 0);
        add(0, 32'h0, 32'h0, 3'b000, 0, 1, 32'h0, 1, 0);
        add(0, 32'h0, 32'h0, W, 0, 1, 32'hD4C3B2A1, 0, 0);
        add(1, 32'h7FC, 32'h99AA1234, W, 0, 0, 32'h0, 0, 0);
`ifdef MEM_CTRL_RANGE_CHECK_EN
        add(1, 32'h7FE, 32'h55667788, W, 0, 1, 32'h0, 1, 0);
        add(0, 32'h7FE, 32'h0,        W, 0, 1, 32'h0, 1, 0);
        add(0, 32'h7FC, 32'h0, W, 0, 1, 32'h99AA1234, 0, 0);
        add(0, 32'h0,   32'h0, W, 0, 1, 32'hD4C3B2A1, 0, 0);
`else
        add(1, 32'h7FE, 32'h55667788, W, 0, 0, 32'h0, 0, 1);
        add(0, 32'h7FE, 32'h0,        W, 0, 1, 32'h55667788, 0, 1);
        add(0, 32'h7FC, 32'h0, W, 0, 1, 32'h77881234, 0, 0);
        add(0, 32'h0,   32'h0, W, 0, 1, 32'hD4C35566, 0, 0);
`endif

        foreach (tbl[i]) issue(tbl[i]);
        d_req = 1'b0;
        drain();

        iaddr = 32'h12; #1 check("iread_0x12", {16'h0, iread}, 32'h0000DEAD);
        iaddr = 32'h11; #1 check("iread_0x11", {16'h0, iread}, 32'h0000BEEF);
        iaddr = 32'h3;  #1 check("iread_0x03", {16'h0, iread}, 32'h0000D4C3);
        @(negedge clock);

`ifndef MEM_CTRL_RANGE_CHECK_EN
        // Split write abandoned by reset: only beat 1 (byte 0x7FF) lands.
        d_req = 1'b1; d_we = 1'b1; daddr = 32'h7FF; dwdata = 32'hAABBCCDD; dsize = W; dread_se = 1'b0;
        @(posedge clock);
        #1;
        check("rst_mid_busy_before", {31'h0, d_busy}, 32'h1);
        d_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_mid_busy", {31'h0, d_busy}, 32'h0);
        check("rst_mid_done", {31'h0, d_done}, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_done_after", {31'h0, d_done}, 32'h0);
        rd(32'h7FC, W, 0, 32'hDD881234, 0);
        rd(32'h0,   W, 0, 32'hD4C35566, 0);
        rd(32'h7FE, W, 0, 32'h5566DD88, 1);
        d_req = 1'b0;
        drain();
`endif

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
